// File: rtl/search_arbiter_if.sv
// search_arbiter_if: control and result bus between the arbiter and the binary-search engine
interface search_arbiter_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5
);
  logic              eng_start;
  logic              eng_reset;
  logic [DATA_W-1:0] eng_A;
  logic              eng_f;
  logic              eng_nf;
  logic [ADDR_W-1:0] eng_addr;
  modport master (output eng_start, eng_reset, eng_A, input eng_f, eng_nf, eng_addr);
  modport slave  (input eng_start, eng_reset, eng_A, output eng_f, eng_nf, eng_addr);
endinterface

// File: rtl/search_arbiter.sv
// search_arbiter: two-requester round-robin sequencer for the shared binary-search engine
module search_arbiter #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 5,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic [DATA_W-1:0] key0,
  input  logic              req1,
  input  logic [DATA_W-1:0] key1,
  output logic              done0,
  output logic              done1,
  output logic              found,
  output logic              not_found,
  output logic              timed_out,
  output logic [ADDR_W-1:0] res_addr,
  output logic [1:0]        grant,
  output logic              busy,
  search_arbiter_if.master  eng
);
  typedef enum logic [2:0] {IDLE, LAUNCH, SETTLE, BUSY, RESP} state_t;
  localparam logic [7:0] LIM = 8'(TIMEOUT - 1);
  state_t     state;
  logic       last;
  logic       pick;
  logic [7:0] cnt;
  assign pick = req1 && (!req0 || !last);
  assign eng.eng_reset = reset || timed_out;
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      last          <= 1'b1;
      cnt           <= '0;
      done0         <= 1'b0;
      done1         <= 1'b0;
      found         <= 1'b0;
      not_found     <= 1'b0;
      timed_out     <= 1'b0;
      res_addr      <= '0;
      grant         <= 2'b00;
      busy          <= 1'b0;
      eng.eng_start <= 1'b0;
      eng.eng_A     <= '0;
    end else begin
      case (state)
        IDLE: if (req0 || req1) begin
          grant         <= pick ? 2'b10 : 2'b01;
          eng.eng_A     <= pick ? key1 : key0;
          busy          <= 1'b1;
          eng.eng_start <= 1'b1;
          state         <= LAUNCH;
        end
        LAUNCH: begin
          eng.eng_start <= 1'b0;
          state         <= SETTLE;
        end
        SETTLE: begin
          cnt   <= '0;
          state <= BUSY;
        end
        BUSY: begin
          cnt <= cnt + 8'd1;
          if (eng.eng_f || eng.eng_nf || cnt == LIM) begin
            found     <= eng.eng_f;
            not_found <= !eng.eng_f && eng.eng_nf;
            timed_out <= !eng.eng_f && !eng.eng_nf;
            res_addr  <= eng.eng_f ? eng.eng_addr : '0;
            done0     <= grant[0];
            done1     <= grant[1];
            state     <= RESP;
          end
        end
        RESP: begin
          last      <= grant[1];
          done0     <= 1'b0;
          done1     <= 1'b0;
          found     <= 1'b0;
          not_found <= 1'b0;
          timed_out <= 1'b0;
          res_addr  <= '0;
          grant     <= 2'b00;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
